// File: rtl/des3_wb_master.sv
// Wishbone initiator for one triple-DES operation on the DES3 register slave:
// loads data/keys, pulses start, polls ct_valid with a gap, then reads the 64-bit result.
module des3_wb_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          POLL_GAP  = 4,
  parameter int          MAX_POLLS = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_data,
  input  logic [55:0] req_key1,
  input  logic [55:0] req_key2,
  input  logic [55:0] req_key3,
  input  logic        req_decrypt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [1:0]  rsp_err,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic [31:0] wb_dat_i
);

  localparam int PCW = ($clog2(MAX_POLLS + 1) > 11) ? $clog2(MAX_POLLS + 1) : 11;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_START, S_WAIT, S_POLL, S_RD_HI, S_RD_LO, S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             stb_q, stb_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic             we_q, we_d;
  logic [15:0]      gap_q, gap_d;
  logic [PCW-1:0]   pcnt_q, pcnt_d;
  logic [63:0]      rdata_q, rdata_d;
  logic [1:0]       rerr_q, rerr_d;
  logic [63:0]      data_q, data_d;
  logic [55:0]      k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
  logic             dec_q, dec_d;

  logic             bus_st, done, acc_we;
  logic [3:0]       acc_reg;
  logic [31:0]      acc_dat, wr_word;

  always_comb begin
    wr_word = 32'h0;
    case (idx_q)
      4'd1:    wr_word = {31'b0, dec_q};
      4'd2:    wr_word = data_q[31:0];
      4'd3:    wr_word = data_q[63:32];
      4'd4:    wr_word = {4'b0, k3_q[27:0]};
      4'd5:    wr_word = {4'b0, k3_q[55:28]};
      4'd6:    wr_word = {4'b0, k2_q[27:0]};
      4'd7:    wr_word = {4'b0, k2_q[55:28]};
      4'd8:    wr_word = {4'b0, k1_q[27:0]};
      4'd9:    wr_word = {4'b0, k1_q[55:28]};
      default: wr_word = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stb_d   = stb_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    gap_d   = gap_q;
    pcnt_d  = pcnt_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    data_d  = data_q;
    k1_d    = k1_q;
    k2_d    = k2_q;
    k3_d    = k3_q;
    dec_d   = dec_q;
    done    = 1'b0;
    bus_st  = 1'b0;
    acc_reg = 4'd0;
    acc_dat = 32'h0;
    acc_we  = 1'b0;

    case (state_q)
      S_WRITE: begin bus_st = 1'b1; acc_reg = idx_q; acc_dat = wr_word; acc_we = 1'b1; end
      S_START: begin bus_st = 1'b1; acc_reg = 4'd0;  acc_dat = 32'h1;   acc_we = 1'b1; end
      S_POLL:  begin bus_st = 1'b1; acc_reg = 4'd10; end
      S_RD_HI: begin bus_st = 1'b1; acc_reg = 4'd11; end
      S_RD_LO: begin bus_st = 1'b1; acc_reg = 4'd12; end
      default: ;
    endcase

    // stb only rises from a low cycle, so the slave's registered strobe always clears between accesses
    if (bus_st) begin
      if (!stb_q) begin
        stb_d = 1'b1;
        adr_d = BASE_ADDR + {26'b0, acc_reg, 2'b00};
        dat_d = acc_dat;
        we_d  = acc_we;
      end else if (wb_err_i) begin
        stb_d   = 1'b0;
        we_d    = 1'b0;
        rerr_d  = 2'd1;
        rdata_d = 64'h0;
        state_d = S_RESP;
      end else if (wb_ack_i) begin
        stb_d = 1'b0;
        we_d  = 1'b0;
        done  = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          data_d  = req_data;
          k1_d    = req_key1;
          k2_d    = req_key2;
          k3_d    = req_key3;
          dec_d   = req_decrypt;
          idx_d   = 4'd1;
          pcnt_d  = '0;
          rdata_d = 64'h0;
          rerr_d  = 2'd0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (done) begin
          if (idx_q == 4'd9) state_d = S_START;
          else               idx_d   = idx_q + 4'd1;
        end
      end
      S_START: begin
        if (done) begin
          gap_d   = 16'h0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (gap_q == 16'(POLL_GAP - 1)) begin
          gap_d   = 16'h0;
          state_d = S_POLL;
        end else begin
          gap_d = gap_q + 16'h1;
        end
      end
      S_POLL: begin
        if (done) begin
          if (wb_dat_i[0]) begin
            state_d = S_RD_HI;
          end else if (pcnt_q + PCW'(1) == PCW'(MAX_POLLS)) begin
            rerr_d  = 2'd2;
            rdata_d = 64'h0;
            state_d = S_RESP;
          end else begin
            pcnt_d  = pcnt_q + PCW'(1);
            state_d = S_WAIT;
          end
        end
      end
      S_RD_HI: begin
        if (done) begin
          rdata_d[63:32] = wb_dat_i;
          state_d        = S_RD_LO;
        end
      end
      S_RD_LO: begin
        if (done) begin
          rdata_d[31:0] = wb_dat_i;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      stb_q   <= 1'b0;
      adr_q   <= 32'h0;
      dat_q   <= 32'h0;
      we_q    <= 1'b0;
      gap_q   <= 16'h0;
      pcnt_q  <= '0;
      rdata_q <= 64'h0;
      rerr_q  <= 2'd0;
      data_q  <= 64'h0;
      k1_q    <= 56'h0;
      k2_q    <= 56'h0;
      k3_q    <= 56'h0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stb_q   <= stb_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      gap_q   <= gap_d;
      pcnt_q  <= pcnt_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      data_q  <= data_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      k3_q    <= k3_d;
      dec_q   <= dec_d;
    end
  end

  assign req_ready = (state_q == S_IDLE) & ~wb_rst_i;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rdata_q;
  assign rsp_err   = rerr_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_we_o   = we_q;
  assign wb_stb_o  = stb_q;
  assign wb_cyc_o  = stb_q;
  assign wb_sel_o  = 4'hF;

endmodule

// File: tb/tb_des3_wb_master.sv
// Bench for des3_wb_master: register-slave BFM, access-sequence model built from the
// register map, and a per-cycle bus/response checker.
module tb_des3_wb_master;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int GAP  = 4;
  localparam int MAXP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_decrypt, rsp_valid, rsp_ready;
  logic [63:0] req_data, rsp_data;
  logic [55:0] req_key1, req_key2, req_key3;
  logic [1:0]  rsp_err;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err;

  des3_wb_master #(.BASE_ADDR(BASE), .POLL_GAP(GAP), .MAX_POLLS(MAXP)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_key1(req_key1), .req_key2(req_key2), .req_key3(req_key3), .req_decrypt(req_decrypt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
    .wb_dat_i(wb_dat_i)
  );

  int compared = 0;
  int mism = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_adr(input int n);
    return BASE + 32'(4 * n);
  endfunction

  // slave BFM: ack = registered(stb) & stb; optional error on one write register
  logic        stb_r;
  int          poll_seen = 0;
  int          ct_poll = 0;
  int          err_reg = 0;
  logic [63:0] ct_val = 64'h0;
  logic        stray_en = 1'b0;
  logic        err_hit, poll_ok;

  always @(posedge clk or posedge rst) begin
    if (rst) stb_r <= 1'b0;
    else     stb_r <= wb_stb;
  end
  assign err_hit  = stb_r & wb_stb & wb_we & (err_reg != 0) & (wb_adr == reg_adr(err_reg));
  assign wb_ack   = (stb_r & wb_stb & ~err_hit) | (stray_en & ~wb_stb);
  assign wb_err   = err_hit | (stray_en & ~wb_stb);
  assign poll_ok  = (ct_poll != 0) && (poll_seen >= ct_poll);
  assign wb_dat_i = (wb_adr == reg_adr(10)) ? {31'b0, poll_ok} :
                    (wb_adr == reg_adr(11)) ? ct_val[63:32] :
                    (wb_adr == reg_adr(12)) ? ct_val[31:0] : 32'hDEAD_BEEF;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } acc_t;
  acc_t log_q[$];
  acc_t exp_q[$];
  logic [63:0] exp_rsp_data = 64'h0;
  logic [1:0]  exp_rsp_err = 2'd0;

  // expected access sequence from the register map and the slave's behaviour
  task automatic build_exp(input logic [63:0] d, input logic [55:0] k1, k2, k3,
                           input logic dec, input int ctp, input int erg, input logic [63:0] ct);
    logic [31:0] w[1:9];
    int npoll;
    bool_blk: begin end
    w[1] = {31'b0, dec};       w[2] = d[31:0];            w[3] = d[63:32];
    w[4] = {4'b0, k3[27:0]};   w[5] = {4'b0, k3[55:28]};
    w[6] = {4'b0, k2[27:0]};   w[7] = {4'b0, k2[55:28]};
    w[8] = {4'b0, k1[27:0]};   w[9] = {4'b0, k1[55:28]};
    exp_q.delete();
    for (int n = 1; n <= 9; n++) begin
      if (erg == 0 || n <= erg) exp_q.push_back({1'b1, reg_adr(n), w[n]});
    end
    if (erg != 0) begin
      exp_rsp_err = 2'd1; exp_rsp_data = 64'h0;
    end else begin
      exp_q.push_back({1'b1, reg_adr(0), 32'h1});
      npoll = (ctp >= 1 && ctp <= MAXP) ? ctp : MAXP;
      for (int p = 0; p < npoll; p++) exp_q.push_back({1'b0, reg_adr(10), 32'h0});
      if (ctp >= 1 && ctp <= MAXP) begin
        exp_q.push_back({1'b0, reg_adr(11), 32'h0});
        exp_q.push_back({1'b0, reg_adr(12), 32'h0});
        exp_rsp_err = 2'd0; exp_rsp_data = ct;
      end else begin
        exp_rsp_err = 2'd2; exp_rsp_data = 64'h0;
      end
    end
  endtask

  // per-cycle checker and access logger
  logic        p_stb = 0, p_ack = 0, p_err = 0, p_we = 0, p_rv = 0, p_rr = 0;
  logic [31:0] p_adr = 0, p_dat = 0;
  logic [63:0] p_rdata = 0;
  always @(negedge clk) begin
    if (rst) begin
      p_stb = 0; p_ack = 0; p_err = 0; p_rv = 0; p_rr = 0;
    end else begin
      check("cyc_eq_stb", wb_cyc, wb_stb);
      check("sel", wb_sel, 4'hF);
      if (p_stb && (p_ack || p_err)) begin
        check("stb_drop_after_ack", wb_stb, 0);
      end else if (p_stb) begin
        check("stb_held_until_ack", wb_stb, 1);
        check("adr_stable", wb_adr, p_adr);
        check("dat_stable", wb_dat_o, p_dat);
        check("we_stable", wb_we, p_we);
      end
      if (rsp_valid) begin
        check("rsp_data", rsp_data, exp_rsp_data);
        check("rsp_err", rsp_err, exp_rsp_err);
        check("req_ready_in_resp", req_ready, 0);
      end
      if (p_rv && !p_rr) begin
        check("rsp_valid_held", rsp_valid, 1);
        check("rsp_data_held", rsp_data, p_rdata);
      end
      if (wb_stb && (wb_ack || wb_err)) begin
        log_q.push_back({wb_we, wb_adr, wb_we ? wb_dat_o : 32'h0});
        if (wb_adr == reg_adr(10)) poll_seen++;
      end
      p_stb = wb_stb; p_ack = wb_ack; p_err = wb_err; p_we = wb_we;
      p_adr = wb_adr; p_dat = wb_dat_o; p_rv = rsp_valid; p_rr = rsp_ready; p_rdata = rsp_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] got_data;
  logic [1:0]  got_err;

  task automatic run_op(input logic [63:0] d, input logic [55:0] k1, k2, k3, input logic dec,
                        input int ctp, input int erg, input int hold, input logic [63:0] ct);
    int n;
    int nlog;
    ct_val = ct; ct_poll = ctp; err_reg = erg; poll_seen = 0;
    log_q.delete();
    build_exp(d, k1, k2, k3, dec, ctp, erg, ct);
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    check("req_ready_idle", req_ready, 1);
    req_valid = 1; req_data = d; req_key1 = k1; req_key2 = k2; req_key3 = k3; req_decrypt = dec;
    tick();
    req_valid = 0;
    check("req_ready_busy", req_ready, 0);
    n = 0;
    while (!rsp_valid && n < 3000) begin tick(); n++; end
    check("rsp_valid_seen", rsp_valid, 1);
    got_data = rsp_data; got_err = rsp_err;
    if (hold > 0) begin
      nlog = log_q.size();
      req_valid = 1; req_data = ~d;
      for (int i = 0; i < hold; i++) begin
        tick();
        check("hold_req_ready", req_ready, 0);
      end
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_no_new_access", log_q.size(), nlog);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0; req_valid = 0;
    check("rsp_valid_after_hs", rsp_valid, 0);
    check("req_ready_after_hs", req_ready, 1);
    check("access_count", log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      check($sformatf("access_%0d", i), log_q[i], exp_q[i]);
  endtask

  function automatic int count_writes();
    int c = 0;
    foreach (log_q[i]) if (log_q[i].we) c++;
    return c;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    req_valid = 0; rsp_ready = 0; req_decrypt = 0;
    req_data = 64'h0; req_key1 = 56'h0; req_key2 = 56'h0; req_key3 = 56'h0;

    // reset state
    repeat (3) tick();
    check("rst_stb", wb_stb, 0);
    check("rst_cyc", wb_cyc, 0);
    check("rst_we", wb_we, 0);
    check("rst_adr", wb_adr, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_sel", wb_sel, 4'hF);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    rst = 0;
    #1;
    check("req_ready_after_rst", req_ready, 1);

    // encrypt, ct_valid on 3rd poll
    run_op(64'h0123456789ABCDEF, 56'h12695BC9B7B7F8, 56'h12695BC9B7B7F8, 56'h12695BC9B7B7F8,
           1'b0, 3, 0, 0, 64'h85E813540F0AB405);
    check("t1_rsp_data_lit", got_data, 64'h85E813540F0AB405);
    check("t1_rsp_err_lit", got_err, 0);
    check("t1_writes_lit", count_writes(), 10);
    check("t1_polls_lit", poll_seen, 3);
    check("t1_pin_data_lo", exp_q[1].dat, 32'h89ABCDEF);
    check("t1_pin_k1_lo", exp_q[7].dat, 32'h09B7B7F8);
    check("t1_pin_k1_hi", exp_q[8].dat, 32'h012695BC);
    check("t1_pin_len", exp_q.size(), 15);

    // bus error on write to reg 6
    run_op(64'hFEDCBA9876543210, 56'hAAAAAAA5555555, 56'h0F0F0F0F0F0F0F, 56'h13579BDF2468AC,
           1'b1, 2, 6, 0, 64'h1111_2222_3333_4444);
    check("t4_rsp_err_lit", got_err, 1);
    check("t4_rsp_data_lit", got_data, 0);
    check("t4_accesses_lit", log_q.size(), 6);

    // poll timeout
    run_op(64'h0000_0000_FFFF_FFFF, 56'h1, 56'h2, 56'h3, 1'b0, 0, 0, 0, 64'h0);
    check("t3_rsp_err_lit", got_err, 2);
    check("t3_rsp_data_lit", got_data, 0);
    check("t3_polls_lit", poll_seen, 8);

    // backpressure with stray ack/err while strobe is low
    stray_en = 1;
    run_op(64'hA5A5_5A5A_C3C3_3C3C, 56'hFFFFFFFFFFFFFF, 56'h80000000000001, 56'h00000010000000,
           1'b1, 1, 0, 20, 64'hCAFE_F00D_0BAD_BEEF);
    stray_en = 0;
    check("t5_rsp_data_lit", got_data, 64'hCAFE_F00D_0BAD_BEEF);
    check("t5_polls_lit", poll_seen, 1);

    // reset while polling
    ct_poll = 0; err_reg = 0; poll_seen = 0;
    log_q.delete();
    req_valid = 1; req_data = 64'h1; req_decrypt = 0;
    tick();
    req_valid = 0;
    n = 0;
    while (!(wb_stb && wb_adr == reg_adr(10)) && n < 1000) begin tick(); n++; end
    check("t6_reached_poll", wb_stb && (wb_adr == reg_adr(10)), 1);
    #2 rst = 1;
    #1;
    check("t6_stb_now", wb_stb, 0);
    check("t6_cyc_now", wb_cyc, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_req_ready_in_rst", req_ready, 0);
    repeat (2) tick();
    rst = 0;
    #1;
    check("t6_req_ready_after", req_ready, 1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (wb_stb || rsp_valid) n++;
    end
    check("t6_quiet_after_rst", n, 0);

    // normal operation after reset
    run_op(64'h0011_2233_4455_6677, 56'h0123456789ABCD, 56'hFEDCBA98765432, 56'h00FF00FF00FF00,
           1'b1, 8, 0, 0, 64'h8899_AABB_CCDD_EEFF);
    check("t7_rsp_data_lit", got_data, 64'h8899_AABB_CCDD_EEFF);
    check("t7_polls_lit", poll_seen, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
